// File: rtl/adaptation_step_scheduler.sv
// Turns the adaptation controller's phase/iteration outputs into decimated tap
// update requests, each carrying an update mode and a gear-shifted mu_shift.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              global advance enable (freezes FSM and counters when 0)
//   adaptation_phase    0 startup, 1 CMA, 2 LMS, 3..7 invalid (treated as startup)
//   iteration_count     iterations within the current phase (drives gear shifting)
//   sample_valid        one equalized sample this cycle
//   update_req/ack      request/acknowledge handshake with the tap update engine
//   update_mode         0 none, 1 CMA, 2 LMS; valid while update_req
//   mu_shift            step-size right shift; valid while update_req
//   active_phase        phase currently being served
//   phase_change        one-cycle pulse when active_phase changes
//   update_count        completed handshakes (wrapping)
//   overrun             sticky: decimation boundary hit while a request was pending
//   phase_error         sticky: invalid adaptation_phase observed
module adaptation_step_scheduler #(
  parameter int unsigned DECIM        = 4,
  parameter int unsigned FLUSH_CYCLES = 8,
  parameter int unsigned CMA_MU_INIT  = 6,
  parameter int unsigned CMA_MU_MAX   = 10,
  parameter int unsigned LMS_MU_INIT  = 8,
  parameter int unsigned LMS_MU_MAX   = 14,
  parameter int unsigned GEAR_SHIFT   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  adaptation_phase,
  input  logic [31:0] iteration_count,
  input  logic        sample_valid,
  output logic        update_req,
  input  logic        update_ack,
  output logic [1:0]  update_mode,
  output logic [3:0]  mu_shift,
  output logic [1:0]  active_phase,
  output logic        phase_change,
  output logic [31:0] update_count,
  output logic        overrun,
  output logic        phase_error
);

  localparam int unsigned DCW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned MU_W = 5;

  typedef enum logic [1:0] {IDLE, FLUSH, COLLECT, REQUEST} state_t;

  state_t            state_q, state_d;
  logic [DCW-1:0]    decim_q, decim_d;
  logic [FCW-1:0]    flush_q, flush_d;
  logic              req_q, req_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        mu_q, mu_d;
  logic [1:0]        active_q, active_d;
  logic              pc_q, pc_d;
  logic [31:0]       count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              perr_q, perr_d;

  logic              phase_invalid;
  logic [1:0]        eff_phase;
  logic [31:0]       gear_full;
  logic [3:0]        gear;
  logic [MU_W-1:0]   mu_init, mu_max, mu_sum;
  logic [3:0]        target_mu;
  logic              decim_last;

  // Invalid phases collapse to startup
  always_comb begin
    phase_invalid = (adaptation_phase > 3'd2);
    eff_phase     = phase_invalid ? 2'd0 : adaptation_phase[1:0];
  end

  // Gear-shifted step size, saturated to the active phase's maximum
  always_comb begin
    gear_full = iteration_count >> GEAR_SHIFT;
    gear      = (gear_full > 32'd15) ? 4'd15 : gear_full[3:0];
    if (active_q == 2'd2) begin
      mu_init = MU_W'(LMS_MU_INIT);
      mu_max  = MU_W'(LMS_MU_MAX);
    end else begin
      mu_init = MU_W'(CMA_MU_INIT);
      mu_max  = MU_W'(CMA_MU_MAX);
    end
    mu_sum    = mu_init + {1'b0, gear};
    target_mu = (mu_sum > mu_max) ? mu_max[3:0] : mu_sum[3:0];
  end

  assign decim_last = (decim_q == DCW'(DECIM - 1));

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      decim_q   <= '0;
      flush_q   <= '0;
      req_q     <= 1'b0;
      mode_q    <= 2'd0;
      mu_q      <= 4'd0;
      active_q  <= 2'd0;
      pc_q      <= 1'b0;
      count_q   <= 32'd0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      decim_q   <= decim_d;
      flush_q   <= flush_d;
      req_q     <= req_d;
      mode_q    <= mode_d;
      mu_q      <= mu_d;
      active_q  <= active_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    flush_d   = flush_q;
    req_d     = req_q;
    mode_d    = mode_q;
    mu_d      = mu_q;
    active_d  = active_q;
    pc_d      = 1'b0;
    count_d   = count_q;
    overrun_d = overrun_q;
    perr_d    = perr_q | phase_invalid;

    // Phase change outside REQUEST: restart flush for 1/2, drop to IDLE for 0
    if (enable && (state_q != REQUEST) && (eff_phase != active_q)) begin
      state_d  = (eff_phase != 2'd0) ? FLUSH : IDLE;
      active_d = eff_phase;
      flush_d  = '0;
      decim_d  = '0;
      pc_d     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          decim_d = '0;
        end
        FLUSH: begin
          if (enable) begin
            if (flush_q == FCW'(FLUSH_CYCLES - 1)) begin
              state_d = COLLECT;
              flush_d = '0;
              decim_d = '0;
            end else begin
              flush_d = flush_q + FCW'(1);
            end
          end
        end
        COLLECT: begin
          if (enable && sample_valid) begin
            if (decim_last) begin
              decim_d = '0;
              state_d = REQUEST;
              req_d   = 1'b1;
              mode_d  = active_q;
              mu_d    = target_mu;
            end else begin
              decim_d = decim_q + DCW'(1);
            end
          end
        end
        REQUEST: begin
          // Samples keep counting; a boundary while still pending is dropped
          if (enable && sample_valid) begin
            if (decim_last) begin
              decim_d   = '0;
              overrun_d = 1'b1;
            end else begin
              decim_d = decim_q + DCW'(1);
            end
          end
          // Ack completes regardless of enable; pending phase change is seen next cycle
          if (update_ack) begin
            req_d   = 1'b0;
            mode_d  = 2'd0;
            mu_d    = 4'd0;
            count_d = count_q + 32'd1;
            state_d = COLLECT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign update_req   = req_q;
  assign update_mode  = mode_q;
  assign mu_shift     = mu_q;
  assign active_phase = active_q;
  assign phase_change = pc_q;
  assign update_count = count_q;
  assign overrun      = overrun_q;
  assign phase_error  = perr_q;

endmodule

// File: doc/adaptation_step_scheduler.md
Name: adaptation_step_scheduler

Overview:
Consumer of the equalizer adaptation phase/iteration outputs: converts phase (0 startup, 1 CMA, 2 LMS) and iteration count into decimated tap-update requests for the tap update engine, each with an update mode and a gear-shifted step size (mu as right-shift). Handles phase-change flushing and the req/ack handshake with the update engine. Sits between the adaptation controller and the FFE/DFE tap update datapath.

Parameters:
DECIM, 4, samples per tap update (>=1)
FLUSH_CYCLES, 8, enabled cycles with no updates after entering a new phase (>=1)
CMA_MU_INIT, 6, initial mu_shift in CMA
CMA_MU_MAX, 10, saturation mu_shift in CMA
LMS_MU_INIT, 8, initial mu_shift in LMS
LMS_MU_MAX, 14, saturation mu_shift in LMS
GEAR_SHIFT, 10, gear period = 2^GEAR_SHIFT iterations

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  global advance enable
adaptation_phase  in  3  0 startup, 1 CMA, 2 LMS, 3-7 invalid
iteration_count  in  32  iterations within current phase
sample_valid  in  1  one equalized sample this cycle
update_req  out  1  tap update request
update_ack  in  1  update engine accepted request
update_mode  out  2  0 none, 1 CMA, 2 LMS; valid while update_req
mu_shift  out  4  step-size right shift; valid while update_req
active_phase  out  2  phase currently being served (0/1/2)
phase_change  out  1  one-cycle pulse when active_phase changes
update_count  out  32  completed handshakes, wraps at 2^32
overrun  out  1  sticky: decimation boundary reached while a request was pending
phase_error  out  1  sticky: adaptation_phase in 3..7 seen

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM IDLE; decim_cnt=0, flush_cnt=0.
- Phase input 3..7: treated as startup; set phase_error (sticky until reset).
- Target mu = min(INIT + min(iteration_count >> GEAR_SHIFT, 15), MAX), using the INIT/MAX of the active phase; computed in >=5 bits before saturation; result fits 4 bits.
- FSM states:
  - IDLE: no requests; decim_cnt held at 0. If a valid phase 1/2 is seen with enable=1 -> FLUSH; active_phase latched; phase_change pulses on the next cycle.
  - FLUSH: flush_cnt increments on each enable=1 cycle; samples are ignored. After FLUSH_CYCLES enabled cycles -> COLLECT with decim_cnt=0.
  - COLLECT: on sample_valid&enable, decim_cnt increments. The DECIM-th sample sets decim_cnt to 0 and moves to REQUEST. On the next cycle update_req=1; update_mode=active_phase; mu_shift=target mu, latched at that sample.
  - REQUEST: update_req, update_mode and mu_shift stay stable until update_ack. A cycle with ack=1 while req=1 completes the handshake: req=0, update_mode=0 next cycle, update_count+1, -> COLLECT. Samples keep counting. If the decimation boundary is reached again before ack: set overrun, drop that boundary, restart decim_cnt at 0.
- Phase change (adaptation_phase != active_phase):
  - In IDLE/FLUSH/COLLECT, acted on when enable=1: new phase 1/2 -> FLUSH (flush_cnt=0, decim_cnt=0); phase 0/invalid -> IDLE, active_phase=0. phase_change pulses once either way.
  - In REQUEST: deferred until ack; re-evaluated in the cycle after ack.
- enable=0: FSM, flush_cnt and decim_cnt freeze; an outstanding request stays asserted and ack is still accepted.
- update_ack while update_req=0: ignored.
- Same-cycle ack and phase change in REQUEST: the ack completes first, then the phase change is taken the next cycle.

Test Plan:
- Reset, then phase=1, iteration_count=0, continuous samples, ack one cycle after req -> phase_change pulse. No req during 8 flush cycles. Then req every 4 samples with mode=1, mu_shift=6. update_count increments per ack.
- CMA with iteration_count=3072 (GEAR_SHIFT=10) -> mu_shift=9. iteration_count=100000 -> mu_shift saturates at 10.
- Switch phase 1->2 while in COLLECT -> phase_change pulse, active_phase=2, 8-cycle flush. Next req has mode=2, mu_shift=8.
- Hold ack low for 6 samples with DECIM=4 -> req/mode/mu stable, overrun=1. After ack, count +1 and normal operation resumes.
- Phase 2->0 while req pending, ack 3 cycles later -> req held until ack, then IDLE, active_phase=0, no further req. phase=5 -> phase_error=1.
- Assert rst mid-REQUEST -> all outputs 0 immediately. After release with phase=1 -> flush restarts from 0.
